scoreboard: RTL and testbench

//  In-order reorder buffer between decode/issue and commit. Stores each issued scoreboard_entry in a

---
 rtl/ariane_pkg.sv | 41 ++++
 rtl/scoreboard.sv | 150 +++++++++++++++
 tb/tb_scoreboard.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared core types used by the scoreboard and its neighbours.
//   NR_SB_ENTRIES    : default scoreboard depth
//   TRANS_ID_BITS    : width of a transaction ID (index into the scoreboard)
//   fu_t             : functional unit class; NONE marks "no writer"
//   exception        : exception record produced by a functional unit
//   scoreboard_entry : one decoded instruction as tracked from issue to commit
package ariane_pkg;

   localparam int unsigned NR_SB_ENTRIES = 8;
   localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

   typedef enum logic [3:0] {
      NONE      = 4'd0,
      LSU       = 4'd1,
      ALU       = 4'd2,
      CTRL_FLOW = 4'd3,
      MULT      = 4'd4,
      CSR       = 4'd5,
      FPU       = 4'd6
   } fu_t;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception;

   typedef struct packed {
      logic [63:0] pc;
      fu_t         fu;
      logic [7:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] result;
      logic        valid;     // result has been written back
      logic        use_imm;
      exception    ex;
   } scoreboard_entry;

endpackage

// File: rtl/scoreboard.sv
// In-order reorder buffer between issue and commit.
// Issued entries are stored in a circular buffer indexed by transaction ID,
// completed out of order by FU writebacks, and released to commit in
// program order. Also exports per-register clobber info and result
// forwarding for the issue logic.
// Ports:
//   clk_i, rst_i (sync, active high), flush_i (drop everything)
//   full_o                                   : buffer holds NR_ENTRIES entries
//   issue_instr_i/issue_valid_i              : enqueue request
//   issue_trans_id_o                         : ID the next accepted entry gets
//   wb_valid_i/wb_trans_id_i/wb_data_i/wb_ex_i : FU writeback
//   commit_instr_o/commit_valid_o/commit_ack_i : oldest entry and pop
//   rd_clobber_o                             : youngest in-flight writer per register
//   rs1_i/rs2_i -> rs1_o/rs2_o, rs1_fwd_o/rs2_fwd_o : operand forwarding
module scoreboard
   import ariane_pkg::*;
#(
   parameter int unsigned NR_ENTRIES = NR_SB_ENTRIES,
   localparam int unsigned TID = $clog2(NR_ENTRIES)
)(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   output logic            full_o,
   input  scoreboard_entry issue_instr_i,
   input  logic            issue_valid_i,
   output logic [TID-1:0]  issue_trans_id_o,
   input  logic            wb_valid_i,
   input  logic [TID-1:0]  wb_trans_id_i,
   input  logic [63:0]     wb_data_i,
   input  exception        wb_ex_i,
   output scoreboard_entry commit_instr_o,
   output logic            commit_valid_o,
   input  logic            commit_ack_i,
   output fu_t             rd_clobber_o [32],
   input  logic [4:0]      rs1_i,
   input  logic [4:0]      rs2_i,
   output logic [63:0]     rs1_o,
   output logic [63:0]     rs2_o,
   output logic            rs1_fwd_o,
   output logic            rs2_fwd_o
);

   localparam logic [TID:0]   FULL_COUNT = (TID+1)'(NR_ENTRIES);
   localparam logic [TID:0]   CNT_ONE    = (TID+1)'(1);
   localparam logic [TID-1:0] PTR_ONE    = TID'(1);

   scoreboard_entry       r_mem [NR_ENTRIES];
   logic [NR_ENTRIES-1:0] r_occupied;
   logic [TID-1:0]        r_commit_ptr;
   logic [TID-1:0]        r_write_ptr;
   logic [TID:0]          r_count;

   logic                  w_issue_fire;
   logic                  w_commit_fire;
   scoreboard_entry       w_issue_entry;
   logic [TID-1:0]        w_age_idx [NR_ENTRIES];
   logic                  w_rs1_found;
   logic                  w_rs2_found;
   logic [TID-1:0]        w_rs1_sel;
   logic [TID-1:0]        w_rs2_sel;

   // Fullness comes from the registered count only, so a commit in the
   // same cycle never frees room for a push.
   assign full_o           = (r_count == FULL_COUNT);
   assign issue_trans_id_o = r_write_ptr;
   assign commit_instr_o   = r_mem[r_commit_ptr];
   assign commit_valid_o   = r_occupied[r_commit_ptr] && r_mem[r_commit_ptr].valid;
   assign w_issue_fire     = issue_valid_i && !full_o && !flush_i;
   assign w_commit_fire    = commit_valid_o && commit_ack_i;

   // A freshly issued entry is never complete and carries no FU exception yet.
   always_comb begin
      w_issue_entry          = issue_instr_i;
      w_issue_entry.valid    = 1'b0;
      w_issue_entry.ex.valid = 1'b0;
   end

   // w_age_idx[k] is the slot k positions younger than the head.
   generate
      for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_age
         assign w_age_idx[gi] = r_commit_ptr + TID'(gi);
      end
   endgenerate

   // Walk occupied slots oldest to youngest; later (younger) matches
   // overwrite earlier ones, which yields the youngest writer per register.
   always_comb begin
      for (int r = 0; r < 32; r++) begin
         rd_clobber_o[r] = NONE;
      end
      w_rs1_found = 1'b0;
      w_rs2_found = 1'b0;
      w_rs1_sel   = '0;
      w_rs2_sel   = '0;
      for (int k = 0; k < NR_ENTRIES; k++) begin
         if (r_occupied[w_age_idx[k]]) begin
            rd_clobber_o[r_mem[w_age_idx[k]].rd] = r_mem[w_age_idx[k]].fu;
            if (r_mem[w_age_idx[k]].rd == rs1_i) begin
               w_rs1_found = 1'b1;
               w_rs1_sel   = w_age_idx[k];
            end
            if (r_mem[w_age_idx[k]].rd == rs2_i) begin
               w_rs2_found = 1'b1;
               w_rs2_sel   = w_age_idx[k];
            end
         end
      end
      // x0 is hard-wired, so no instruction ever clobbers it.
      rd_clobber_o[0] = NONE;
   end

   // A pending youngest writer masks any older completed one.
   assign rs1_fwd_o = w_rs1_found && (rs1_i != 5'd0) && r_mem[w_rs1_sel].valid;
   assign rs2_fwd_o = w_rs2_found && (rs2_i != 5'd0) && r_mem[w_rs2_sel].valid;
   assign rs1_o     = rs1_fwd_o ? r_mem[w_rs1_sel].result : 64'd0;
   assign rs2_o     = rs2_fwd_o ? r_mem[w_rs2_sel].result : 64'd0;

   // Issue targets an unoccupied slot and writeback only touches occupied
   // ones, so the two memory writes below never hit the same entry.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_occupied   <= '0;
         r_commit_ptr <= '0;
         r_write_ptr  <= '0;
         r_count      <= '0;
      end else begin
         if (w_issue_fire) begin
            r_mem[r_write_ptr]      <= w_issue_entry;
            r_occupied[r_write_ptr] <= 1'b1;
            r_write_ptr             <= r_write_ptr + PTR_ONE;
         end
         if (wb_valid_i && r_occupied[wb_trans_id_i]) begin
            r_mem[wb_trans_id_i].result <= wb_data_i;
            r_mem[wb_trans_id_i].ex     <= wb_ex_i;
            r_mem[wb_trans_id_i].valid  <= 1'b1;
         end
         if (w_commit_fire) begin
            r_occupied[r_commit_ptr] <= 1'b0;
            r_commit_ptr             <= r_commit_ptr + PTR_ONE;
         end
         case ({w_issue_fire, w_commit_fire})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for the scoreboard: directed scenarios plus a random
// run, all checked against a queue-based in-order model.
module tb_scoreboard;
   import ariane_pkg::*;

   localparam int N = NR_SB_ENTRIES;

   logic            clk = 1'b0;
   logic            rst, flush, iv, wbv, ack;
   scoreboard_entry instr, cinstr;
   logic [2:0]      tido, wbtid;
   logic [63:0]     wbdata, rs1o, rs2o;
   exception        wbex;
   logic            full, cvalid, f1, f2;
   fu_t             clob [32];
   logic [4:0]      rs1, rs2;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int          tid;
      logic [4:0]  rd;
      fu_t         fu;
      logic [63:0] result;
      logic        done;
      logic        exv;
   } m_t;
   m_t mq[$];
   int next_tid = 0;

   always #5 clk = ~clk;

   scoreboard #(.NR_ENTRIES(N)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .full_o(full),
      .issue_instr_i(instr), .issue_valid_i(iv), .issue_trans_id_o(tido),
      .wb_valid_i(wbv), .wb_trans_id_i(wbtid), .wb_data_i(wbdata), .wb_ex_i(wbex),
      .commit_instr_o(cinstr), .commit_valid_o(cvalid), .commit_ack_i(ack),
      .rd_clobber_o(clob), .rs1_i(rs1), .rs2_i(rs2), .rs1_o(rs1o), .rs2_o(rs2o),
      .rs1_fwd_o(f1), .rs2_fwd_o(f2)
   );

   function automatic scoreboard_entry mk(input logic [4:0] rd, input fu_t fu);
      scoreboard_entry e;
      e          = '0;
      e.pc       = {$urandom, $urandom};
      e.fu       = fu;
      e.op       = 8'($urandom);
      e.rs1      = 5'($urandom);
      e.rs2      = 5'($urandom);
      e.rd       = rd;
      e.result   = {$urandom, $urandom};
      e.valid    = 1'b1;   // must be dropped on issue
      e.use_imm  = 1'($urandom);
      e.ex.cause = {$urandom, $urandom};
      e.ex.valid = 1'b1;   // must be dropped on issue
      return e;
   endfunction

   function automatic fu_t model_clobber(input logic [4:0] r);
      fu_t f = NONE;
      foreach (mq[i]) if (mq[i].rd == r) f = mq[i].fu;
      if (r == 5'd0) f = NONE;
      return f;
   endfunction

   function automatic void model_fwd(input logic [4:0] r, output logic ok,
                                     output logic found, output logic [63:0] d);
      ok = 1'b0; found = 1'b0; d = '0;
      foreach (mq[i]) if (mq[i].rd == r) begin
         found = 1'b1; ok = mq[i].done; d = mq[i].result;
      end
      if (r == 5'd0) ok = 1'b0;
   endfunction

   // One clock; the model is advanced from the pre-edge inputs and state.
   task automatic cycle();
      bit acc, com;
      acc = iv && (mq.size() < N) && !flush && !rst;
      com = ack && (mq.size() > 0) && mq[0].done;
      @(posedge clk);
      if (rst || flush) begin
         mq.delete();
         next_tid = 0;
      end else begin
         if (wbv) foreach (mq[k]) if (mq[k].tid == int'(wbtid)) begin
            mq[k].done = 1'b1; mq[k].result = wbdata; mq[k].exv = wbex.valid;
         end
         if (com) void'(mq.pop_front());
         if (acc) begin
            mq.push_back('{next_tid, instr.rd, instr.fu, instr.result, 1'b0, 1'b0});
            next_tid = (next_tid + 1) % N;
         end
      end
      #1;
      cyc++;
      $display("cyc %0d rst=%b flush=%b issue=%b acc=%b rd=%0d wb=%b tid=%0d ack=%b com=%b count=%0d",
               cyc, rst, flush, iv, acc, instr.rd, wbv, wbtid, ack, com, mq.size());
   endtask

   task automatic idle();
      iv = 0; wbv = 0; ack = 0; flush = 0; wbtid = '0; wbdata = '0; wbex = '0;
   endtask

   task automatic push(input logic [4:0] rd, input fu_t fu);
      iv = 1'b1; instr = mk(rd, fu); cycle(); iv = 1'b0;
   endtask

   task automatic wb(input int tid, input logic [63:0] d, input logic exv);
      wbv = 1'b1; wbtid = 3'(tid); wbdata = d; wbex = '0; wbex.valid = exv;
      cycle(); wbv = 1'b0;
   endtask

   task automatic do_reset();
      idle(); rst = 1'b1; cycle(); cycle(); rst = 1'b0;
   endtask

   task automatic test_reset();
      instr = mk(5'd1, ALU); rs1 = 5'd1; rs2 = 5'd2;
      do_reset();
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
      n_checks++; if (tido !== 3'd0) begin n_fail++; $display("FAIL reset_tid got %0d exp 0", tido); end
      n_checks++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL reset_cvalid got %b exp 0", cvalid); end
      n_checks++; if (f1 !== 1'b0 || f2 !== 1'b0) begin n_fail++; $display("FAIL reset_fwd got %b%b exp 00", f1, f2); end
      for (int r = 0; r < 32; r++) begin
         n_checks++;
         if (clob[r] !== NONE) begin n_fail++; $display("FAIL reset_clobber[%0d] got %0d exp 0", r, clob[r]); end
      end
   endtask

   task automatic test_fill();
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (tido !== 3'(k)) begin n_fail++; $display("FAIL fill_tid got %0d exp %0d", tido, k); end
         push(5'(k + 1), ALU);
      end
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", full); end
      n_checks++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL fill_cvalid got %b exp 0", cvalid); end
      n_checks++; if (cinstr.valid !== 1'b0 || cinstr.ex.valid !== 1'b0)
         begin n_fail++; $display("FAIL fill_forced got v=%b ex=%b exp 0 0", cinstr.valid, cinstr.ex.valid); end
      push(5'd9, LSU);   // refused: buffer full
      n_checks++; if (tido !== 3'd0) begin n_fail++; $display("FAIL ninth_tid got %0d exp 0", tido); end
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ninth_full got %b exp 1", full); end
      n_checks++; if (clob[9] !== NONE) begin n_fail++; $display("FAIL ninth_clobber got %0d exp 0", clob[9]); end
   endtask

   task automatic test_wb_order();
      wb(2, 64'h2222, 1'b0);
      n_checks++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL wb2_cvalid got %b exp 0", cvalid); end
      wb(0, 64'h1000, 1'b0);
      n_checks++; if (cvalid !== 1'b1) begin n_fail++; $display("FAIL wb0_cvalid got %b exp 1", cvalid); end
      n_checks++; if (cinstr.result !== 64'h1000 || cinstr.rd !== 5'd1)
         begin n_fail++; $display("FAIL wb0_head got rd=%0d res=%0h exp rd=1 res=1000", cinstr.rd, cinstr.result); end
      ack = 1'b1; cycle(); ack = 1'b0;
      n_checks++; if (cvalid !== 1'b0 || cinstr.rd !== 5'd2)
         begin n_fail++; $display("FAIL ack_head got v=%b rd=%0d exp v=0 rd=2", cvalid, cinstr.rd); end
      wb(1, 64'h1111, 1'b1);
      n_checks++; if (cvalid !== 1'b1 || cinstr.ex.valid !== 1'b1)
         begin n_fail++; $display("FAIL exc_head got v=%b ex=%b exp 1 1", cvalid, cinstr.ex.valid); end
      ack = 1'b1; cycle(); ack = 1'b0;
      n_checks++; if (cvalid !== 1'b1 || cinstr.rd !== 5'd3 || cinstr.result !== 64'h2222)
         begin n_fail++; $display("FAIL tid2_head got v=%b rd=%0d res=%0h exp 1 3 2222", cvalid, cinstr.rd, cinstr.result); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL drain_full got %b exp 0", full); end
   endtask

   task automatic test_clobber();
      do_reset();
      push(5'd5, ALU);
      n_checks++; if (clob[5] !== ALU) begin n_fail++; $display("FAIL clob_alu got %0d exp %0d", clob[5], ALU); end
      push(5'd5, LSU);
      n_checks++; if (clob[5] !== LSU) begin n_fail++; $display("FAIL clob_lsu got %0d exp %0d", clob[5], LSU); end
      wb(0, 64'h5, 1'b0); wb(1, 64'h6, 1'b0);
      ack = 1'b1; cycle(); cycle(); ack = 1'b0;
      n_checks++; if (clob[5] !== NONE || cvalid !== 1'b0)
         begin n_fail++; $display("FAIL clob_drained got %0d v=%b exp 0 0", clob[5], cvalid); end
      push(5'd0, ALU);
      n_checks++; if (clob[0] !== NONE) begin n_fail++; $display("FAIL clob_x0 got %0d exp 0", clob[0]); end
   endtask

   task automatic test_forward();
      do_reset();
      push(5'd3, ALU);
      wb(0, 64'hDEAD, 1'b0);
      rs1 = 5'd3; rs2 = 5'd4; #1;
      n_checks++; if (f1 !== 1'b1 || rs1o !== 64'hDEAD)
         begin n_fail++; $display("FAIL fwd_dead got f=%b d=%0h exp 1 dead", f1, rs1o); end
      n_checks++; if (f2 !== 1'b0 || rs2o !== 64'd0)
         begin n_fail++; $display("FAIL fwd_nomatch got f=%b d=%0h exp 0 0", f2, rs2o); end
      push(5'd3, MULT);
      n_checks++; if (f1 !== 1'b0) begin n_fail++; $display("FAIL fwd_masked got %b exp 0", f1); end
      wb(1, 64'hBEEF, 1'b0);
      n_checks++; if (f1 !== 1'b1 || rs1o !== 64'hBEEF)
         begin n_fail++; $display("FAIL fwd_beef got f=%b d=%0h exp 1 beef", f1, rs1o); end
      push(5'd0, ALU); wb(2, 64'h77, 1'b0);
      rs2 = 5'd0; #1;
      n_checks++; if (f2 !== 1'b0) begin n_fail++; $display("FAIL fwd_x0 got %b exp 0", f2); end
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int k = 0; k < 8; k++) push(5'(k + 1), ALU);
      for (int k = 0; k < 8; k++) wb(k, 64'(k), 1'b0);
      iv = 1'b1; instr = mk(5'd20, CSR); ack = 1'b1; cycle(); iv = 1'b0; ack = 1'b0;
      n_checks++; if (full !== 1'b0 || tido !== 3'd0)
         begin n_fail++; $display("FAIL full_commit got full=%b tid=%0d exp 0 0", full, tido); end
      n_checks++; if (clob[20] !== NONE || cinstr.rd !== 5'd2)
         begin n_fail++; $display("FAIL full_refused got clob=%0d rd=%0d exp 0 2", clob[20], cinstr.rd); end
      push(5'd21, CSR);
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL refill_full got %b exp 1", full); end
      do_reset();
      for (int k = 0; k < 20; k++) begin
         n_checks++;
         if (tido !== 3'(k % 8)) begin n_fail++; $display("FAIL wrap_tid got %0d exp %0d", tido, k % 8); end
         push(5'(k % 31 + 1), ALU);
         wb(k % 8, 64'(k) + 64'h100, 1'b0);
         n_checks++;
         if (cvalid !== 1'b1 || cinstr.result !== 64'(k) + 64'h100)
            begin n_fail++; $display("FAIL wrap_head got v=%b res=%0h exp 1 %0h", cvalid, cinstr.result, k + 'h100); end
         ack = 1'b1; cycle(); ack = 1'b0;
      end
      n_checks++; if (cvalid !== 1'b0 || tido !== 3'd4)
         begin n_fail++; $display("FAIL wrap_end got v=%b tid=%0d exp 0 4", cvalid, tido); end
   endtask

   task automatic test_flush();
      do_reset();
      push(5'd10, ALU); push(5'd11, LSU); push(5'd12, MULT);
      wb(0, 64'hAA, 1'b0);
      iv = 1'b1; instr = mk(5'd13, ALU); wbv = 1'b1; wbtid = 3'd1; wbdata = 64'hBB;
      ack = 1'b1; flush = 1'b1; rs1 = 5'd10; rs2 = 5'd13;
      cycle(); idle();
      n_checks++; if (full !== 1'b0 || tido !== 3'd0 || cvalid !== 1'b0)
         begin n_fail++; $display("FAIL flush_state got full=%b tid=%0d v=%b exp 0 0 0", full, tido, cvalid); end
      n_checks++; if (f1 !== 1'b0 || f2 !== 1'b0) begin n_fail++; $display("FAIL flush_fwd got %b%b exp 00", f1, f2); end
      for (int r = 10; r < 14; r++) begin
         n_checks++;
         if (clob[r] !== NONE) begin n_fail++; $display("FAIL flush_clobber[%0d] got %0d exp 0", r, clob[r]); end
      end
      cycle();
      n_checks++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL flush_after got %b exp 0", cvalid); end
   endtask

   task automatic test_random();
      logic ok, found;
      logic [63:0] d;
      do_reset();
      for (int t = 0; t < 400; t++) begin
         iv     = ($urandom_range(0, 99) < 55);
         instr  = mk(5'($urandom_range(0, 31)), fu_t'(4'($urandom_range(1, 6))));
         wbv    = ($urandom_range(0, 99) < 60);
         wbtid  = 3'($urandom);
         wbdata = {$urandom, $urandom};
         wbex   = '0; wbex.valid = ($urandom_range(0, 9) == 0);
         ack    = ($urandom_range(0, 99) < 50);
         flush  = ($urandom_range(0, 99) < 2);
         rs1    = 5'($urandom_range(0, 31));
         rs2    = 5'($urandom_range(0, 31));
         cycle();
         n_checks++;
         if (full !== (mq.size() == N)) begin n_fail++; $display("FAIL rnd_full got %b exp %b", full, mq.size() == N); end
         n_checks++;
         if (tido !== 3'(next_tid)) begin n_fail++; $display("FAIL rnd_tid got %0d exp %0d", tido, next_tid); end
         ok = (mq.size() > 0) && mq[0].done;
         n_checks++;
         if (cvalid !== ok) begin n_fail++; $display("FAIL rnd_cvalid got %b exp %b", cvalid, ok); end
         if (ok) begin
            n_checks++;
            if (cinstr.rd !== mq[0].rd || cinstr.result !== mq[0].result || cinstr.ex.valid !== mq[0].exv)
               begin n_fail++; $display("FAIL rnd_head got rd=%0d res=%0h ex=%b exp rd=%0d res=%0h ex=%b",
                     cinstr.rd, cinstr.result, cinstr.ex.valid, mq[0].rd, mq[0].result, mq[0].exv); end
         end
         for (int r = 0; r < 32; r++) begin
            n_checks++;
            if (clob[r] !== model_clobber(5'(r)))
               begin n_fail++; $display("FAIL rnd_clobber[%0d] got %0d exp %0d", r, clob[r], model_clobber(5'(r))); end
         end
         model_fwd(rs1, ok, found, d);
         n_checks++;
         if (f1 !== ok) begin n_fail++; $display("FAIL rnd_fwd1 got %b exp %b", f1, ok); end
         if (ok || !found) begin
            n_checks++;
            if (rs1o !== (ok ? d : 64'd0)) begin n_fail++; $display("FAIL rnd_rs1 got %0h exp %0h", rs1o, ok ? d : 64'd0); end
         end
         model_fwd(rs2, ok, found, d);
         n_checks++;
         if (f2 !== ok) begin n_fail++; $display("FAIL rnd_fwd2 got %b exp %b", f2, ok); end
         if (ok || !found) begin
            n_checks++;
            if (rs2o !== (ok ? d : 64'd0)) begin n_fail++; $display("FAIL rnd_rs2 got %0h exp %0h", rs2o, ok ? d : 64'd0); end
         end
      end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      instr = '0; rs1 = '0; rs2 = '0;
      test_reset();
      test_fill();
      test_wb_order();
      test_clobber();
      test_forward();
      test_full_wrap();
      test_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
